// File: rtl/excp_commit_ctrl_pkg.sv
// Shared definitions for the commit-stage exception/ERTN sequencer and the CSR file.
//  - EV_* : bit positions of the one-hot event vector csr_vec[7:0]
//  - state_e : 2-bit FSM state encoding
//  - ECODE_* / ESUBCODE_* : exception codes, plus a helper mapping an event to its code
package excp_commit_ctrl_pkg;

    localparam int unsigned EXCP_W     = 7;
    localparam int unsigned EV_W       = 8;
    localparam int unsigned VEC_W      = 64;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned ECODE_W    = 6;
    localparam int unsigned ESUBCODE_W = 9;

    // Event bit positions; {wb_excp, has_int} lines up with this map directly
    localparam int unsigned EV_INT  = 0;
    localparam int unsigned EV_ERTN = 1;
    localparam int unsigned EV_SYS  = 2;
    localparam int unsigned EV_BRK  = 3;
    localparam int unsigned EV_INE  = 4;
    localparam int unsigned EV_IPE  = 5;
    localparam int unsigned EV_ADEF = 6;
    localparam int unsigned EV_ALE  = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_FLUSH  = 2'd3
    } state_e;

    localparam logic [ECODE_W-1:0]    ECODE_INT     = 6'h00;
    localparam logic [ECODE_W-1:0]    ECODE_ADE     = 6'h08;
    localparam logic [ECODE_W-1:0]    ECODE_ALE     = 6'h09;
    localparam logic [ECODE_W-1:0]    ECODE_SYS     = 6'h0b;
    localparam logic [ECODE_W-1:0]    ECODE_BRK     = 6'h0c;
    localparam logic [ECODE_W-1:0]    ECODE_INE     = 6'h0d;
    localparam logic [ECODE_W-1:0]    ECODE_IPE     = 6'h0e;
    localparam logic [ESUBCODE_W-1:0] ESUBCODE_ADEF = 9'h000;
    localparam logic [ESUBCODE_W-1:0] ESUBCODE_NONE = 9'h000;

    typedef struct packed {
        logic [ECODE_W-1:0]    ecode;
        logic [ESUBCODE_W-1:0] esubcode;
    } excp_code_t;

    // Map a one-hot event to its ecode/esubcode (ERTN and no-event map to zero)
    function automatic excp_code_t ev_code(input logic [EV_W-1:0] ev);
        excp_code_t c;
        c.ecode    = ECODE_INT;
        c.esubcode = ESUBCODE_NONE;
        if (ev[EV_ADEF]) begin
            c.ecode    = ECODE_ADE;
            c.esubcode = ESUBCODE_ADEF;
        end
        else if (ev[EV_ALE]) c.ecode = ECODE_ALE;
        else if (ev[EV_SYS]) c.ecode = ECODE_SYS;
        else if (ev[EV_BRK]) c.ecode = ECODE_BRK;
        else if (ev[EV_INE]) c.ecode = ECODE_INE;
        else if (ev[EV_IPE]) c.ecode = ECODE_IPE;
        return c;
    endfunction

endpackage

// File: rtl/excp_prio_enc.sv
// Combinational priority encoder: {wb_excp, has_int} -> one-hot event.
// Priority high to low: ADEF > INT > SYS > BRK > INE > IPE > ALE > ERTN.
// Ports:
//   excp_i    : {ale,adef,ipe,ine,brk,sys,ertn}
//   int_i     : interrupt pending and enabled
//   ev_oh_c_o : one-hot event in csr_vec[7:0] bit map, zero if nothing pending
module excp_prio_enc
    import excp_commit_ctrl_pkg::*;
(
    input  logic [EXCP_W-1:0] excp_i,
    input  logic              int_i,
    output logic [EV_W-1:0]   ev_oh_c_o
);

    logic [EV_W-1:0] raw;

    assign raw = {excp_i, int_i};

    always_comb begin
        ev_oh_c_o = '0;
        if      (raw[EV_ADEF]) ev_oh_c_o[EV_ADEF] = 1'b1;
        else if (raw[EV_INT])  ev_oh_c_o[EV_INT]  = 1'b1;
        else if (raw[EV_SYS])  ev_oh_c_o[EV_SYS]  = 1'b1;
        else if (raw[EV_BRK])  ev_oh_c_o[EV_BRK]  = 1'b1;
        else if (raw[EV_INE])  ev_oh_c_o[EV_INE]  = 1'b1;
        else if (raw[EV_IPE])  ev_oh_c_o[EV_IPE]  = 1'b1;
        else if (raw[EV_ALE])  ev_oh_c_o[EV_ALE]  = 1'b1;
        else if (raw[EV_ERTN]) ev_oh_c_o[EV_ERTN] = 1'b1;
    end

endmodule

// File: rtl/excp_commit_ctrl.sv
// Commit-stage sequencer for the CSR exception/ERTN path. Latches the winning event of a
// committing instruction, holds it across AXI stalls, then issues a one-cycle one-hot
// csr_vec pulse together with a fetch redirect and a FLUSH_CYCLES-long pipeline flush.
// Ports:
//   clk, resetn          : clock, async active-low reset
//   wb_valid/pc/excp/badv: committing instruction and its exception flags / faulting VA
//   has_int              : interrupt pending (only taken with a committing instruction)
//   stallreq_axi         : CSR busy; events wait while high
//   csr_new_pc           : eentry/era from the CSR, forwarded as redirect_pc in COMMIT
//   csr_vec              : one-hot event pulse ([7:0]), upper bits zero
//   csr_pc, csr_error_va : latched PC and ALE bad VA of the event
//   commit_ready         : high only in IDLE
//   flush, redirect_valid, redirect_pc : pipeline kill and fetch redirect
module excp_commit_ctrl
    import excp_commit_ctrl_pkg::*;
#(
    parameter int unsigned PC_W         = 32,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wb_valid,
    input  logic [PC_W-1:0]   wb_pc,
    input  logic [EXCP_W-1:0] wb_excp,
    input  logic [PC_W-1:0]   wb_badv,
    input  logic              has_int,
    input  logic              stallreq_axi,
    input  logic [PC_W-1:0]   csr_new_pc,
    output logic [VEC_W-1:0]  csr_vec,
    output logic [PC_W-1:0]   csr_pc,
    output logic [PC_W-1:0]   csr_error_va,
    output logic              commit_ready,
    output logic              flush,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc
);

    state_e            state_q, state_d;
    logic [EV_W-1:0]   ev_q, ev_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   badv_q, badv_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [EV_W-1:0]   ev_oh;
    logic              take;

    excp_prio_enc u_prio_enc (
        .excp_i    (wb_excp),
        .int_i     (has_int),
        .ev_oh_c_o (ev_oh)
    );

    // An event is accepted only in IDLE; wb_* in any other state is ignored
    assign take = (state_q == ST_IDLE) && wb_valid && (|ev_oh);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Event latches and flush counter; reset drops any pending event
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ev_q   <= '0;
            pc_q   <= '0;
            badv_q <= '0;
            cnt_q  <= '0;
        end
        else begin
            ev_q   <= ev_d;
            pc_q   <= pc_d;
            badv_q <= badv_d;
            cnt_q  <= cnt_d;
        end
    end

    // Next-state and latch-update logic
    always_comb begin
        state_d = state_q;
        ev_d    = ev_q;
        pc_d    = pc_q;
        badv_d  = badv_q;
        cnt_d   = cnt_q;

        if (take) begin
            ev_d   = ev_oh;
            pc_d   = wb_pc;
            badv_d = ev_oh[EV_ALE] ? wb_badv : '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (take) state_d = stallreq_axi ? ST_WAIT : ST_COMMIT;
            end
            ST_WAIT: begin
                if (!stallreq_axi) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                // Counter counts the COMMIT cycle as the first flush cycle
                cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                state_d = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        csr_vec        = '0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        commit_ready   = 1'b0;
        case (state_q)
            ST_IDLE:   commit_ready = 1'b1;
            ST_COMMIT: begin
                csr_vec        = VEC_W'(ev_q);
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = csr_new_pc;
            end
            ST_FLUSH:  flush = 1'b1;
            default:   ;
        endcase
    end

    assign csr_pc       = pc_q;
    assign csr_error_va = badv_q;

endmodule

// File: tb/tb_excp_commit_ctrl.sv
// Directed bench for excp_commit_ctrl: a default build (FLUSH_CYCLES=2) and a
// FLUSH_CYCLES=1 build share the stimulus; each check names the instance it looks at.
module tb_excp_commit_ctrl;

    localparam int unsigned PC_W = 32;

    logic            clk;
    logic            resetn;
    logic            wb_valid;
    logic [PC_W-1:0] wb_pc;
    logic [6:0]      wb_excp;
    logic [PC_W-1:0] wb_badv;
    logic            has_int;
    logic            stallreq_axi;
    logic [PC_W-1:0] csr_new_pc;

    logic [63:0]     csr_vec,        csr_vec_1;
    logic [PC_W-1:0] csr_pc,         csr_pc_1;
    logic [PC_W-1:0] csr_error_va,   csr_error_va_1;
    logic            commit_ready,   commit_ready_1;
    logic            flush,          flush_1;
    logic            redirect_valid, redirect_valid_1;
    logic [PC_W-1:0] redirect_pc,    redirect_pc_1;

    int n_run;
    int n_fail;

    excp_commit_ctrl #(.PC_W(PC_W), .FLUSH_CYCLES(2)) u_dut (
        .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_excp(wb_excp), .wb_badv(wb_badv), .has_int(has_int),
        .stallreq_axi(stallreq_axi), .csr_new_pc(csr_new_pc),
        .csr_vec(csr_vec), .csr_pc(csr_pc), .csr_error_va(csr_error_va),
        .commit_ready(commit_ready), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    excp_commit_ctrl #(.PC_W(PC_W), .FLUSH_CYCLES(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_excp(wb_excp), .wb_badv(wb_badv), .has_int(has_int),
        .stallreq_axi(stallreq_axi), .csr_new_pc(csr_new_pc),
        .csr_vec(csr_vec_1), .csr_pc(csr_pc_1), .csr_error_va(csr_error_va_1),
        .commit_ready(commit_ready_1), .flush(flush_1),
        .redirect_valid(redirect_valid_1), .redirect_pc(redirect_pc_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are stable and inputs may be changed on return
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one committing instruction for a single cycle
    task automatic fire(input logic [6:0] ex, input logic hi,
                        input logic [PC_W-1:0] pc, input logic [PC_W-1:0] bv);
        wb_valid = 1'b1;
        wb_excp  = ex;
        has_int  = hi;
        wb_pc    = pc;
        wb_badv  = bv;
        tick();
        wb_valid = 1'b0;
        wb_excp  = '0;
        has_int  = 1'b0;
    endtask

    initial begin
        n_run        = 0;
        n_fail       = 0;
        resetn       = 1'b0;
        wb_valid     = 1'b0;
        wb_pc        = '0;
        wb_excp      = '0;
        wb_badv      = '0;
        has_int      = 1'b0;
        stallreq_axi = 1'b0;
        csr_new_pc   = 32'h1c00_8000;
        #1;

        // Reset values
        chk("rst_vec",     csr_vec, 64'h0);
        chk("rst_pc",      64'(csr_pc), 64'h0);
        chk("rst_eva",     64'(csr_error_va), 64'h0);
        chk("rst_ready",   64'(commit_ready), 64'h1);
        chk("rst_flush",   64'(flush), 64'h0);
        chk("rst_rv",      64'(redirect_valid), 64'h0);
        chk("rst_rpc",     64'(redirect_pc), 64'h0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // 1) SYS, no stall: pulse next cycle, flush two cycles, ready on cycle 3
        fire(7'b0000010, 1'b0, 32'h1c00_0100, 32'h0);
        chk("t1_vec",      csr_vec, 64'h04);
        chk("t1_pc",       64'(csr_pc), 64'h1c00_0100);
        chk("t1_eva",      64'(csr_error_va), 64'h0);
        chk("t1_rv",       64'(redirect_valid), 64'h1);
        chk("t1_rpc",      64'(redirect_pc), 64'h1c00_8000);
        chk("t1_flush_c1", 64'(flush), 64'h1);
        chk("t1_ready_c1", 64'(commit_ready), 64'h0);
        tick();
        chk("t1_flush_c2", 64'(flush), 64'h1);
        chk("t1_vec_c2",   csr_vec, 64'h0);
        chk("t1_rv_c2",    64'(redirect_valid), 64'h0);
        chk("t1_ready_c2", 64'(commit_ready), 64'h0);
        tick();
        chk("t1_flush_c3", 64'(flush), 64'h0);
        chk("t1_ready_c3", 64'(commit_ready), 64'h1);

        // 2) Priority: INT over ALE/BRK, ADEF over INT
        fire(7'b1000100, 1'b1, 32'h1c00_0200, 32'h0000_1234);
        chk("t2_int",      csr_vec, 64'h01);
        chk("t2_int_eva",  64'(csr_error_va), 64'h0);
        tick();
        tick();
        fire(7'b1100000, 1'b1, 32'h1c00_0204, 32'h0);
        chk("t2_adef",     csr_vec, 64'h40);
        tick();
        tick();

        // 3) ALE under a 5-cycle stall; a stall rising in COMMIT changes nothing
        stallreq_axi = 1'b1;
        fire(7'b1000000, 1'b0, 32'h1c00_0300, 32'h0000_0ff3);
        for (int i = 0; i < 4; i++) begin
            chk("t3_wait_vec",   csr_vec, 64'h0);
            chk("t3_wait_flush", 64'(flush), 64'h0);
            chk("t3_wait_ready", 64'(commit_ready), 64'h0);
            tick();
        end
        stallreq_axi = 1'b0;
        tick();
        chk("t3_vec",      csr_vec, 64'h80);
        chk("t3_eva",      64'(csr_error_va), 64'h0000_0ff3);
        chk("t3_pc",       64'(csr_pc), 64'h1c00_0300);
        stallreq_axi = 1'b1;
        tick();
        chk("t3_flush2",   64'(flush), 64'h1);
        tick();
        chk("t3_ready",    64'(commit_ready), 64'h1);
        stallreq_axi = 1'b0;

        // 4) ERTN alone redirects to era; INE outranks ERTN
        csr_new_pc = 32'h1c00_0404;
        fire(7'b0000001, 1'b0, 32'h1c00_0400, 32'h0000_0ff3);
        chk("t4_ertn",     csr_vec, 64'h02);
        chk("t4_rpc",      64'(redirect_pc), 64'h1c00_0404);
        chk("t4_eva",      64'(csr_error_va), 64'h0);
        tick();
        tick();
        fire(7'b0001001, 1'b0, 32'h1c00_0408, 32'h0);
        chk("t4_ine",      csr_vec, 64'h10);
        tick();
        tick();
        csr_new_pc = 32'h1c00_8000;

        // 5) Reset during WAIT drops the event; interrupts need a committing instruction
        stallreq_axi = 1'b1;
        fire(7'b0000010, 1'b0, 32'h1c00_0500, 32'h0);
        chk("t5_wait",     64'(commit_ready), 64'h0);
        resetn = 1'b0;
        #1;
        chk("t5_rst_vec",   csr_vec, 64'h0);
        chk("t5_rst_ready", 64'(commit_ready), 64'h1);
        chk("t5_rst_pc",    64'(csr_pc), 64'h0);
        chk("t5_rst_flush", 64'(flush), 64'h0);
        chk("t5_rst_rv",    64'(redirect_valid), 64'h0);
        tick();
        resetn       = 1'b1;
        stallreq_axi = 1'b0;
        tick();
        chk("t5_nopulse",  csr_vec, 64'h0);
        chk("t5_noflush",  64'(flush), 64'h0);
        has_int = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_int_novalid", csr_vec, 64'h0);
            chk("t5_int_ready",   64'(commit_ready), 64'h1);
        end
        has_int = 1'b0;
        fire(7'b0000000, 1'b0, 32'h1c00_0600, 32'h0);
        chk("t5_noev_ready", 64'(commit_ready), 64'h1);
        chk("t5_noev_vec",   csr_vec, 64'h0);

        // 6) FLUSH_CYCLES=1 build, and an event offered during FLUSH is ignored
        fire(7'b0000100, 1'b0, 32'h1c00_0700, 32'h0);
        chk("t6_vec1",     csr_vec_1, 64'h08);
        chk("t6_flush1",   64'(flush_1), 64'h1);
        chk("t6_vec0",     csr_vec, 64'h08);
        tick();
        chk("t6_flush1_c2", 64'(flush_1), 64'h0);
        chk("t6_ready1_c2", 64'(commit_ready_1), 64'h1);
        chk("t6_flush0_c2", 64'(flush), 64'h1);
        wb_valid = 1'b1;
        wb_excp  = 7'b0001000;
        wb_pc    = 32'h1c00_0800;
        tick();
        chk("t6_ign_vec0",   csr_vec, 64'h0);
        chk("t6_ign_ready0", 64'(commit_ready), 64'h1);
        chk("t6_ign_pc0",    64'(csr_pc), 64'h1c00_0700);
        chk("t6_vec1_ine",   csr_vec_1, 64'h10);
        tick();
        wb_valid = 1'b0;
        wb_excp  = '0;
        chk("t6_repres_vec0", csr_vec, 64'h10);
        chk("t6_repres_pc0",  64'(csr_pc), 64'h1c00_0800);
        chk("t6_idle1",       64'(commit_ready_1), 64'h1);
        tick();
        tick();
        chk("t6_end_ready0",  64'(commit_ready), 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
